// File: rtl/rom_arbiter.sv
// Two-port ROM arbiter: fetch and data-load requesters share one single-ported ROM.
// Exactly one transaction is outstanding. A response is held until the owning port accepts it.
module rom_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [31:0]           if_req_addr,
    output logic                  if_rsp_valid,
    output logic [31:0]           if_rsp_data,
    output logic                  if_rsp_err,
    input  logic                  if_rsp_ready,

    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [31:0]           d_req_addr,
    output logic                  d_rsp_valid,
    output logic [31:0]           d_rsp_data,
    output logic                  d_rsp_err,
    input  logic                  d_rsp_ready,

    output logic                  rom_ce,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [31:0]           rom_rdata,
    input  logic                  rom_rdata_valid
);

    typedef enum logic [1:0] {StIdle, StBusy, StHold} state_t;

    // Busy-cycle count at which the ROM is declared unresponsive.
    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;          // 0 = fetch, 1 = data
    logic        last_grant_q, last_grant_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic        hold_err_q, hold_err_d;

    logic        in_idle, in_hold;
    logic        gnt_data, handshake, legal, rsp_done;
    logic [31:0] sel_addr;

    // Arbitration, address check and ROM strobe for the current IDLE cycle.
    always_comb begin
        in_idle   = rst_n && (state_q == StIdle);
        in_hold   = rst_n && (state_q == StHold);
        // Data wins a tie only if fetch was granted last.
        gnt_data  = d_req_valid && (!if_req_valid || !last_grant_q);
        handshake = in_idle && (if_req_valid || d_req_valid);
        sel_addr  = gnt_data ? d_req_addr : if_req_addr;
        legal     = (sel_addr[1:0] == 2'b00) && ((sel_addr >> (ADDR_WIDTH + 2)) == 32'd0);
        rsp_done  = in_hold && (owner_q ? d_rsp_ready : if_rsp_ready);

        if_req_ready = handshake && !gnt_data;
        d_req_ready  = handshake && gnt_data;
        rom_ce       = handshake && legal;
        rom_addr     = rom_ce ? sel_addr[ADDR_WIDTH+1:2] : '0;

        if_rsp_valid = in_hold && !owner_q;
        if_rsp_data  = if_rsp_valid ? hold_data_q : 32'd0;
        if_rsp_err   = if_rsp_valid && hold_err_q;
        d_rsp_valid  = in_hold && owner_q;
        d_rsp_data   = d_rsp_valid ? hold_data_q : 32'd0;
        d_rsp_err    = d_rsp_valid && hold_err_q;
    end

    // Next-state logic for the transaction FSM and its hold register.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        hold_data_d  = hold_data_q;
        hold_err_d   = hold_err_q;
        unique case (state_q)
            StIdle: begin
                if (handshake) begin
                    owner_d      = gnt_data;
                    last_grant_d = gnt_data;
                    cnt_d        = 8'd0;
                    if (legal) begin
                        state_d = StBusy;
                    end else begin
                        state_d     = StHold;
                        hold_data_d = 32'd0;
                        hold_err_d  = 1'b1;
                    end
                end
            end
            StBusy: begin
                if (rom_rdata_valid) begin
                    state_d     = StHold;
                    hold_data_d = rom_rdata;
                    hold_err_d  = 1'b0;
                end else if (cnt_q == CntLast) begin
                    state_d     = StHold;
                    hold_data_d = 32'd0;
                    hold_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StHold: begin
                if (rsp_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 8'd0;
            hold_data_q  <= 32'd0;
            hold_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            hold_data_q  <= hold_data_d;
            hold_err_q   <= hold_err_d;
        end
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, ROM word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 4, max BUSY cycles awaiting ROM data (range 1..255).
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports if_req_valid in 1, if_req_ready out 1, if_req_addr in 32: fetch request, byte address.
REQ-006 SHALL have ports if_rsp_valid out 1, if_rsp_data out 32, if_rsp_err out 1, if_rsp_ready in 1: fetch response.
REQ-007 SHALL have ports d_req_valid, d_req_ready, d_req_addr, d_rsp_valid, d_rsp_data, d_rsp_err, d_rsp_ready: data-load port, same widths and directions as fetch.
REQ-008 SHALL have ports rom_ce out 1, rom_addr out ADDR_WIDTH: ROM read strobe and word address.
REQ-009 SHALL have ports rom_rdata in 32, rom_rdata_valid in 1: ROM registered read data, nominal latency 1 cycle.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, HOLD; exactly one transaction outstanding.
REQ-011 SHALL assert a port's req_ready only in IDLE and only for the granted port; handshake = valid && ready.
REQ-012 SHALL arbitrate in IDLE: one valid requester wins; both valid -> port not granted last wins (round-robin); last_grant updates on each handshake.
REQ-013 SHALL check the granted address: addr[1:0]!=0 -> misaligned; addr[31:ADDR_WIDTH+2]!=0 -> out of range.
REQ-014 SHALL, on a legal handshake, drive rom_ce=1 and rom_addr=addr[ADDR_WIDTH+1:2] combinationally in that cycle, then go to BUSY; rom_ce=0 in every other cycle.
REQ-015 SHALL, on an illegal handshake, not assert rom_ce; go directly to HOLD with err=1, data=0.
REQ-016 SHALL, in BUSY, capture rom_rdata when rom_rdata_valid=1 into a hold register, err=0, go to HOLD.
REQ-017 SHALL count BUSY cycles; TIMEOUT cycles without rom_rdata_valid -> HOLD with err=1, data=0.
REQ-018 SHALL, in HOLD, assert rsp_valid only on the owning port, with held data/err stable until that port's rsp_ready=1.
REQ-019 SHALL, in HOLD with rsp_ready=1, return to IDLE next cycle; a new request is accepted no earlier than that IDLE cycle (peak throughput 1 per 3 cycles).
REQ-020 SHALL ignore rom_rdata_valid in IDLE and HOLD (late/stray data dropped).
REQ-021 SHALL drive non-owning port's rsp_valid=0, rsp_data=0, rsp_err=0 at all times.
REQ-022 SHALL ignore rsp_ready on a port with no pending response.
REQ-023 SHALL accept a requester dropping req_valid before handshake without any side effect.

Reset
REQ-024 SHALL, with rst_n=0 at a clock edge, enter IDLE, clear timeout counter, hold register to 0, last_grant=data (fetch wins first tie).
REQ-025 SHALL hold all outputs 0 during reset: rom_ce, both req_ready, both rsp_valid/rsp_data/rsp_err; rom_addr=0.
REQ-026 SHALL, on reset mid-BUSY or mid-HOLD, discard the transaction; no response is later delivered for it.

Verification
REQ-027 SHALL pass: fetch only, addr 0x00000010, rom returns 0x00A00093 next cycle -> rom_ce 1 cycle with rom_addr=4; if_rsp_valid in 3rd cycle, data 0x00A00093, err 0.
REQ-028 SHALL pass: both ports valid every cycle after reset -> grants alternate fetch, data, fetch, data; no port granted twice in a row.
REQ-029 SHALL pass: d_req_addr 0x00000006 -> no rom_ce, d_rsp_valid with err=1, data=0; d_req_addr 0x00040000 (ADDR_WIDTH=16) -> err=1.
REQ-030 SHALL pass: ROM model never asserts rom_rdata_valid -> response err=1 after exactly 4 BUSY cycles.
REQ-031 SHALL pass: if_rsp_ready held 0 for 10 cycles in HOLD -> data stable, d_req_ready stays 0, no rom_ce; release -> IDLE next cycle.
REQ-032 SHALL pass: rst_n=0 during BUSY -> all outputs 0, state IDLE, late rom_rdata_valid produces no rsp_valid.
